// File: rtl/clint_define.sv
// rtl/clint_define.sv - shared constants and FSM state type for the CLINT timer scheduler
// Contents:
//   CLINT_MTIMECMP_WIDTH - width of one mtimecmp entry
//   CLINT_HART_NUM       - default number of harts
//   clint_sched_state_e  - scheduler FSM states (IDLE, SCAN)
package clint_define;

  localparam int CLINT_MTIMECMP_WIDTH = 64;
  localparam int CLINT_HART_NUM       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } clint_sched_state_e;

endpackage

// File: rtl/clint_cmp_bank.sv
// rtl/clint_cmp_bank.sv - per-hart mtimecmp register array with half writes and readback
// Ports:
//   clk_i       in  1          - clock
//   rst_n_i     in  1          - asynchronous active-low reset (entries reset to all-ones)
//   wr_i        in  1          - write strobe
//   wr_hart_i   in  HART_IDX_W - hart targeted by the write
//   wr_hi_i     in  1          - 1: write bits [63:32], 0: write bits [31:0]
//   wdat_i      in  32         - write data
//   rd_hart_i   in  HART_IDX_W - hart selected for readback
//   rd_hi_i     in  1          - readback half select
//   rdat_o      out 32         - combinational readback (0 for an out-of-range hart)
//   scan_idx_i  in  HART_IDX_W - hart currently being scanned
//   scan_cmp_o  out 64         - full mtimecmp of the scanned hart
module clint_cmp_bank
  import clint_define::*;
#(
  parameter int HART_NUM   = CLINT_HART_NUM,
  parameter int HART_IDX_W = $clog2(HART_NUM)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            wr_i,
  input  logic [HART_IDX_W-1:0]           wr_hart_i,
  input  logic                            wr_hi_i,
  input  logic [31:0]                     wdat_i,
  input  logic [HART_IDX_W-1:0]           rd_hart_i,
  input  logic                            rd_hi_i,
  output logic [31:0]                     rdat_o,
  input  logic [HART_IDX_W-1:0]           scan_idx_i,
  output logic [CLINT_MTIMECMP_WIDTH-1:0] scan_cmp_o
);

  logic [31:0] cmp_lo [HART_NUM];
  logic [31:0] cmp_hi [HART_NUM];

  // An index >= HART_NUM matches no entry, so such writes fall away here.
  for (genvar h = 0; h < HART_NUM; h++) begin : g_entry
    logic wr_sel;
    assign wr_sel = wr_i && (wr_hart_i == HART_IDX_W'(h));

    dfferh #(.W(32)) u_lo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (wr_sel && !wr_hi_i),
      .d_i     (wdat_i),
      .q_o     (cmp_lo[h])
    );

    dfferh #(.W(32)) u_hi (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (wr_sel && wr_hi_i),
      .d_i     (wdat_i),
      .q_o     (cmp_hi[h])
    );
  end

  // Compare-by-index muxes: an unmatched (out-of-range) index leaves the zero default.
  always_comb begin
    rdat_o     = '0;
    scan_cmp_o = '0;
    for (int h = 0; h < HART_NUM; h++) begin
      if (rd_hart_i == HART_IDX_W'(h)) begin
        rdat_o = rd_hi_i ? cmp_hi[h] : cmp_lo[h];
      end
      if (scan_idx_i == HART_IDX_W'(h)) begin
        scan_cmp_o = {cmp_hi[h], cmp_lo[h]};
      end
    end
  end

endmodule

// File: rtl/clint_dff.sv
// rtl/clint_dff.sv - enable flops with asynchronous active-low reset (reset-low and reset-high)
// Ports (both modules):
//   clk_i   in  1 - clock
//   rst_n_i in  1 - asynchronous active-low reset
//   en_i    in  1 - load enable
//   d_i     in  W - next value
//   q_o     out W - registered value (dffer resets to 0, dfferh resets to all-ones)
module dffer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

module dfferh #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= '1;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/clint_tmr_sched.sv
// rtl/clint_tmr_sched.sv - round-robin scheduler sharing one 64-bit mtime/mtimecmp comparator across harts
// Ports:
//   clk_i         in  1          - clock
//   rst_n_i       in  1          - asynchronous active-low reset
//   mtime_i       in  64         - current mtime
//   mtime_upd_i   in  1          - pulse when mtime increments
//   cmp_wr_i      in  1          - mtimecmp write strobe
//   cmp_wr_hart_i in  HART_IDX_W - hart targeted by the write
//   cmp_wr_hi_i   in  1          - write half select
//   cmp_wdat_i    in  32         - write data
//   cmp_rd_hart_i in  HART_IDX_W - hart selected for readback
//   cmp_rd_hi_i   in  1          - readback half select
//   cmp_rdat_o    out 32         - combinational readback
//   tmr_irq_o     out HART_NUM   - registered per-hart timer interrupt
//   busy_o        out 1          - high while scanning
module clint_tmr_sched
  import clint_define::*;
#(
  parameter int HART_NUM   = CLINT_HART_NUM,
  parameter int HART_IDX_W = $clog2(HART_NUM)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [CLINT_MTIMECMP_WIDTH-1:0] mtime_i,
  input  logic                            mtime_upd_i,
  input  logic                            cmp_wr_i,
  input  logic [HART_IDX_W-1:0]           cmp_wr_hart_i,
  input  logic                            cmp_wr_hi_i,
  input  logic [31:0]                     cmp_wdat_i,
  input  logic [HART_IDX_W-1:0]           cmp_rd_hart_i,
  input  logic                            cmp_rd_hi_i,
  output logic [31:0]                     cmp_rdat_o,
  output logic [HART_NUM-1:0]             tmr_irq_o,
  output logic                            busy_o
);

  localparam logic [HART_IDX_W-1:0] LAST_IDX = HART_IDX_W'(HART_NUM - 1);

  clint_sched_state_e              state_q, state_d;
  logic [HART_IDX_W-1:0]           idx_q, idx_d;
  logic                            pend_q, pend_d;
  logic                            trig;
  logic                            scan_en;
  logic [CLINT_MTIMECMP_WIDTH-1:0] scan_cmp;
  logic                            mtime_ge;

  // Simultaneous mtime update and compare write collapse into one trigger.
  assign trig = mtime_upd_i | cmp_wr_i;

  clint_cmp_bank #(
    .HART_NUM   (HART_NUM),
    .HART_IDX_W (HART_IDX_W)
  ) u_cmp_bank (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_i       (cmp_wr_i),
    .wr_hart_i  (cmp_wr_hart_i),
    .wr_hi_i    (cmp_wr_hi_i),
    .wdat_i     (cmp_wdat_i),
    .rd_hart_i  (cmp_rd_hart_i),
    .rd_hi_i    (cmp_rd_hi_i),
    .rdat_o     (cmp_rdat_o),
    .scan_idx_i (idx_q),
    .scan_cmp_o (scan_cmp)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // A trigger seen before the last slot is remembered in pend and forces a full
  // rescan, so any hart already passed in this round is re-evaluated.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    scan_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx_q != LAST_IDX) begin
          idx_d  = idx_q + 1'b1;
          pend_d = pend_q | trig;
        end else if (pend_q | trig) begin
          idx_d  = '0;
          pend_d = 1'b0;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign busy_o   = (state_q == SCAN);
  assign mtime_ge = (mtime_i >= scan_cmp);

  // Each interrupt bit loads only in its own hart's scan slot; writes never
  // touch it directly, so a split lo/hi update cannot glitch the output.
  for (genvar h = 0; h < HART_NUM; h++) begin : g_irq
    dffer #(.W(1)) u_irq (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (scan_en && (idx_q == HART_IDX_W'(h))),
      .d_i     (mtime_ge),
      .q_o     (tmr_irq_o[h])
    );
  end

endmodule

// File: tb/tb_clint_tmr_sched.sv
// tb/tb_clint_tmr_sched.sv - directed self-checking bench for clint_tmr_sched (4 harts)
module tb_clint_tmr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mtime;
  logic        upd;
  logic        cmp_wr;
  logic [1:0]  wr_hart;
  logic        wr_hi;
  logic [31:0] wdat;
  logic [1:0]  rd_hart;
  logic        rd_hi;
  logic [31:0] rdat;
  logic [3:0]  irq;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clint_tmr_sched #(.HART_NUM(4), .HART_IDX_W(2)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .mtime_i       (mtime),
    .mtime_upd_i   (upd),
    .cmp_wr_i      (cmp_wr),
    .cmp_wr_hart_i (wr_hart),
    .cmp_wr_hi_i   (wr_hi),
    .cmp_wdat_i    (wdat),
    .cmp_rd_hart_i (rd_hart),
    .cmp_rd_hi_i   (rd_hi),
    .cmp_rdat_o    (rdat),
    .tmr_irq_o     (irq),
    .busy_o        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: busy_o=%b after %0d cycles, required 0", tag, busy, k);
    end
  endtask

  task automatic wr_cmp(input logic [1:0] h, input logic hi, input logic [31:0] d);
    cmp_wr  = 1'b1;
    wr_hart = h;
    wr_hi   = hi;
    wdat    = d;
    tick();
    cmp_wr  = 1'b0;
  endtask

  task automatic pulse_upd(input logic [63:0] t);
    mtime = t;
    upd   = 1'b1;
    tick();
    upd   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    mtime   = '0;
    upd     = 1'b0;
    cmp_wr  = 1'b0;
    wr_hart = '0;
    wr_hi   = 1'b0;
    wdat    = '0;
    rd_hart = 2'd2;
    rd_hi   = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (irq !== 4'b0000) begin n_bad++; $display("FAIL reset_irq: got %b, required 0000", irq); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++;
    if (rdat !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_rd_h2_hi: got %h, required ffffffff", rdat); end
    rd_hart = 2'd0;
    rd_hi   = 1'b0;
    #1;
    n_cmp++;
    if (rdat !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_rd_h0_lo: got %h, required ffffffff", rdat); end
  endtask

  task automatic test_irq_rise();
    wr_cmp(2'd1, 1'b0, 32'd5);
    wr_cmp(2'd1, 1'b1, 32'd0);
    wait_idle("rise_wr_idle");
    rd_hart = 2'd1;
    rd_hi   = 1'b0;
    #1;
    n_cmp++;
    if (rdat !== 32'd5) begin n_bad++; $display("FAIL rd_h1_lo: got %h, required 00000005", rdat); end
    rd_hi = 1'b1;
    #1;
    n_cmp++;
    if (rdat !== 32'd0) begin n_bad++; $display("FAIL rd_h1_hi: got %h, required 00000000", rdat); end
    for (int t = 1; t <= 4; t++) begin
      pulse_upd(64'(t));
      wait_idle("rise_pre_idle");
    end
    n_cmp++;
    if (irq !== 4'b0000) begin n_bad++; $display("FAIL rise_below: got %b, required 0000", irq); end
    mtime = 64'd5;
    upd   = 1'b1;
    tick();
    upd   = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rise_busy_t1: got %b, required 1", busy); end
    tick();
    n_cmp++;
    if (irq !== 4'b0000) begin n_bad++; $display("FAIL rise_t2: got %b, required 0000", irq); end
    tick();
    n_cmp++;
    if (irq !== 4'b0010) begin n_bad++; $display("FAIL rise_t3: got %b, required 0010", irq); end
    wait_idle("rise_idle");
    n_cmp++;
    if (irq !== 4'b0010) begin n_bad++; $display("FAIL rise_final: got %b, required 0010", irq); end
  endtask

  task automatic test_irq_fall();
    int  fall_at;
    logic other;
    pulse_upd(64'd7);
    wait_idle("fall_pre_idle");
    n_cmp++;
    if (irq !== 4'b0010) begin n_bad++; $display("FAIL fall_pre: got %b, required 0010", irq); end
    fall_at = 0;
    other   = 1'b0;
    wr_cmp(2'd1, 1'b1, 32'd1);
    for (int i = 1; i <= 9; i++) begin
      if (irq[1] === 1'b0 && fall_at == 0) fall_at = i;
      if ((irq & 4'b1101) !== 4'b0000) other = 1'b1;
      tick();
    end
    n_cmp++;
    if (fall_at != 3) begin n_bad++; $display("FAIL fall_cycle: got %0d, required 3", fall_at); end
    n_cmp++;
    if (other !== 1'b0) begin n_bad++; $display("FAIL fall_other: got %b, required 0", other); end
    wait_idle("fall_idle");
  endtask

  task automatic test_pend();
    int   cnt;
    logic run;
    logic b9;
    cnt = 0;
    run = 1'b1;
    b9  = 1'bx;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (run && busy === 1'b1) cnt++;
      else run = 1'b0;
      if (i == 9) b9 = busy;
      upd = (i == 2);
      tick();
    end
    upd = 1'b0;
    n_cmp++;
    if (cnt != 8) begin n_bad++; $display("FAIL pend_busy_len: got %0d, required 8", cnt); end
    n_cmp++;
    if (b9 !== 1'b0) begin n_bad++; $display("FAIL pend_busy_t9: got %b, required 0", b9); end
  endtask

  task automatic test_same_slot();
    wr_cmp(2'd3, 1'b1, 32'd0);
    wait_idle("slot_pre_idle");
    n_cmp++;
    if (irq !== 4'b0000) begin n_bad++; $display("FAIL slot_pre: got %b, required 0000", irq); end
    upd = 1'b1;
    tick();
    upd = 1'b0;
    repeat (3) tick();
    cmp_wr  = 1'b1;
    wr_hart = 2'd3;
    wr_hi   = 1'b0;
    wdat    = 32'd3;
    tick();
    cmp_wr  = 1'b0;
    n_cmp++;
    if (irq !== 4'b0000) begin n_bad++; $display("FAIL slot_old_value: got %b, required 0000", irq); end
    repeat (4) tick();
    n_cmp++;
    if (irq !== 4'b1000) begin n_bad++; $display("FAIL slot_rescan: got %b, required 1000", irq); end
    wait_idle("slot_idle");
  endtask

  task automatic test_back_to_back();
    int   cnt;
    logic run;
    logic gap;
    wr_cmp(2'd0, 1'b1, 32'd0);
    wait_idle("b2b_pre_idle");
    mtime   = 64'd8;
    upd     = 1'b1;
    cmp_wr  = 1'b1;
    wr_hart = 2'd0;
    wr_hi   = 1'b0;
    wdat    = 32'd10;
    tick();
    upd    = 1'b0;
    cmp_wr = 1'b0;
    cnt = 0;
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (run && busy === 1'b1) cnt++;
      else run = 1'b0;
      tick();
    end
    n_cmp++;
    if (cnt != 4) begin n_bad++; $display("FAIL simul_one_trig: got %0d, required 4", cnt); end
    n_cmp++;
    if (irq !== 4'b1000) begin n_bad++; $display("FAIL simul_irq: got %b, required 1000", irq); end
    gap = 1'b0;
    for (int t = 9; t <= 20; t++) begin
      mtime = 64'(t);
      upd   = 1'b1;
      tick();
      if (busy !== 1'b1) gap = 1'b1;
    end
    upd = 1'b0;
    n_cmp++;
    if (gap !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_gap: got %b, required 0", gap); end
    wait_idle("b2b_idle");
    n_cmp++;
    if (irq !== 4'b1001) begin n_bad++; $display("FAIL b2b_irq: got %b, required 1001", irq); end
  endtask

  task automatic test_reset_mid();
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (irq !== 4'b0000) begin n_bad++; $display("FAIL rstmid_irq: got %b, required 0000", irq); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    rd_hart = 2'd3;
    rd_hi   = 1'b0;
    #1;
    n_cmp++;
    if (rdat !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rstmid_rd_h3_lo: got %h, required ffffffff", rdat); end
    rd_hart = 2'd0;
    rd_hi   = 1'b1;
    #1;
    n_cmp++;
    if (rdat !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rstmid_rd_h0_hi: got %h, required ffffffff", rdat); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (irq !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got irq=%b busy=%b, required irq=0000 busy=0", irq, busy);
    end
    pulse_upd(64'd20);
    wait_idle("rstmid_idle");
    n_cmp++;
    if (irq !== 4'b0000) begin n_bad++; $display("FAIL rstmid_rescan: got %b, required 0000", irq); end
  endtask

  initial begin
    test_reset();
    test_irq_rise();
    test_irq_fall();
    test_pend();
    test_same_slot();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
